// File: rtl/freq_gate_counter.sv
// ============================================================================
// freq_gate_counter
// ----------------------------------------------------------------------------
// Gated edge counter that closes the auto-ranging loop around the frequency
// meter's range prescaler. It counts rising edges of the prescaled signal over
// a fixed window of GATE_CYCLES clk cycles. It then publishes the count as BCD,
// tagged with the range in which the count was taken. It also steers the
// prescaler's range select.
//
// Parameters
//   GATE_CYCLES    clk cycles per gate window (>= 4)
//   DIGITS         BCD digits of the result; full scale = 10^DIGITS-1
//   SETTLE_CYCLES  dead cycles after a range change, edges ignored (>= 1)
//
// Ports
//   clk         in   system clock, rising edge
//   rst_n       in   asynchronous active-low reset
//   signal_in   in   prescaled signal, asynchronous to clk
//   range       out  to prescaler: 0 = pass-through, 1 = divide
//   result_bcd  out  last published count, digit 0 in bits [3:0]
//   result_rng  out  range in effect when result_bcd was gated
//   result_ovf  out  result saturated (all 9s) while on range 1
//   valid       out  1-cycle pulse: result_* updated this cycle
// ============================================================================
module freq_gate_counter #(
    parameter int GATE_CYCLES   = 1000000,
    parameter int DIGITS        = 4,
    parameter int SETTLE_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  signal_in,
    output logic                  range,
    output logic [4*DIGITS-1:0]   result_bcd,
    output logic                  result_rng,
    output logic                  result_ovf,
    output logic                  valid
);

    localparam int TMAX = (GATE_CYCLES > SETTLE_CYCLES) ? GATE_CYCLES : SETTLE_CYCLES;
    localparam int TW   = $clog2(TMAX);

    localparam logic [TW-1:0] GATE_LAST   = TW'(GATE_CYCLES - 1);
    localparam logic [TW-1:0] SETTLE_LAST = TW'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_GATE   = 2'd0,
        ST_LATCH  = 2'd1,
        ST_SETTLE = 2'd2
    } state_t;

    state_t                state, state_next;
    logic [TW-1:0]         timer, timer_next;
    logic [4*DIGITS-1:0]   bcd_cnt, bcd_inc;
    logic                  ovf_flag;
    logic                  all_nines;
    logic                  msd_zero;
    logic                  range_next;
    logic                  count_en;
    logic                  clear_cnt;
    logic                  publish;
    logic                  pub_ovf;

    // The 2-FF synchroniser and the edge-detect stage.
    logic                  sync1, sync2, sync3;
    logic                  edge_q;

    // ------------------------------------------------------------------------
    // BCD +1 with ripple carry. A carry out of the top digit means that every
    // digit was 9. In that case the counter saturates instead of wrapping.
    // ------------------------------------------------------------------------
    always_comb begin
        logic carry;
        carry   = 1'b1;
        bcd_inc = bcd_cnt;
        for (int i = 0; i < DIGITS; i++) begin
            if (carry) begin
                if (bcd_cnt[4*i +: 4] == 4'd9) begin
                    bcd_inc[4*i +: 4] = 4'd0;
                end else begin
                    bcd_inc[4*i +: 4] = bcd_cnt[4*i +: 4] + 4'd1;
                    carry             = 1'b0;
                end
            end
        end
        all_nines = carry;
    end

    assign msd_zero = (bcd_cnt[4*DIGITS-1 -: 4] == 4'd0);

    // ------------------------------------------------------------------------
    // Next-state and control logic.
    // ------------------------------------------------------------------------
    always_comb begin
        // NOTE: every output of this block gets a default value first. A path
        // that leaves an output unassigned would infer a latch.
        state_next = state;
        timer_next = timer;
        range_next = range;
        count_en   = 1'b0;
        clear_cnt  = 1'b0;
        publish    = 1'b0;
        pub_ovf    = 1'b0;

        unique case (state)
            ST_GATE: begin
                count_en = edge_q;
                if (timer == GATE_LAST) begin
                    timer_next = '0;
                    state_next = ST_LATCH;
                end else begin
                    timer_next = timer + TW'(1);
                end
            end

            ST_LATCH: begin
                // Edges in this cycle are dropped because count_en stays low.
                clear_cnt  = 1'b1;
                timer_next = '0;
                if (ovf_flag && !range) begin
                    // Over full scale while in pass-through: switch to the
                    // divider and discard this window.
                    range_next = 1'b1;
                    state_next = ST_SETTLE;
                end else if (ovf_flag) begin
                    // Already dividing: report a saturated reading.
                    publish    = 1'b1;
                    pub_ovf    = 1'b1;
                    state_next = ST_GATE;
                end else if (range && msd_zero) begin
                    // The reading is too small for the divider. Publish it,
                    // then switch back to pass-through.
                    publish    = 1'b1;
                    range_next = 1'b0;
                    state_next = ST_SETTLE;
                end else begin
                    publish    = 1'b1;
                    state_next = ST_GATE;
                end
            end

            ST_SETTLE: begin
                if (timer == SETTLE_LAST) begin
                    timer_next = '0;
                    state_next = ST_GATE;
                end else begin
                    timer_next = timer + TW'(1);
                end
            end

            default: begin
                timer_next = '0;
                state_next = ST_GATE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1      <= 1'b0;
            sync2      <= 1'b0;
            sync3      <= 1'b0;
            edge_q     <= 1'b0;
            state      <= ST_GATE;
            timer      <= '0;
            bcd_cnt    <= '0;
            ovf_flag   <= 1'b0;
            range      <= 1'b0;
            result_bcd <= '0;
            result_rng <= 1'b0;
            result_ovf <= 1'b0;
            valid      <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments make every flop sample the
            // pre-edge value. This is what makes sync1->sync2->sync3 a real
            // shift chain.
            sync1  <= signal_in;
            sync2  <= sync1;
            sync3  <= sync2;
            edge_q <= sync2 & ~sync3;

            state  <= state_next;
            timer  <= timer_next;
            range  <= range_next;
            valid  <= publish;

            if (publish) begin
                result_bcd <= bcd_cnt;
                result_rng <= range;
                result_ovf <= pub_ovf;
            end

            if (clear_cnt) begin
                bcd_cnt  <= '0;
                ovf_flag <= 1'b0;
            end else if (count_en) begin
                if (all_nines) begin
                    ovf_flag <= 1'b1;
                end else begin
                    bcd_cnt <= bcd_inc;
                end
            end
        end
    end

endmodule

// File: tb/tb_freq_gate_counter.sv
// ============================================================================
// tb_freq_gate_counter
// ----------------------------------------------------------------------------
// Bench for freq_gate_counter with GATE_CYCLES=1000, DIGITS=2, SETTLE_CYCLES=16.
// A raw square wave (or random noise) passes through a behavioural x10
// prescaler. The prescaler is steered by the DUT's range output.
//
// The reference model sees every rising edge of signal_in. Each edge reaches
// the counter three clk edges after it is first sampled. The model counts the
// edges that land inside each gate window. It then applies the auto-ranging
// rules with plain integer arithmetic and queues the expected publications.
// A monitor compares each publication against the DUT output whenever valid
// is seen.
// ============================================================================
module tb_freq_gate_counter;

    localparam int G        = 1000;
    localparam int D        = 2;
    localparam int S        = 16;
    localparam int FULL     = 99;   // 10^D - 1
    localparam int MSD_MIN  = 10;   // 10^(D-1)
    localparam int LATENCY  = 3;    // first sample -> counted clk edge

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           signal_in = 1'b0;
    logic           range;
    logic [4*D-1:0] result_bcd;
    logic           result_rng;
    logic           result_ovf;
    logic           valid;

    freq_gate_counter #(
        .GATE_CYCLES   (G),
        .DIGITS        (D),
        .SETTLE_CYCLES (S)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .signal_in  (signal_in),
        .range      (range),
        .result_bcd (result_bcd),
        .result_rng (result_rng),
        .result_ovf (result_ovf),
        .valid      (valid)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [4*D-1:0] to_bcd(input int v);
        logic [4*D-1:0] r;
        int             p;
        r = '0;
        p = 1;
        for (int i = 0; i < D; i++) begin
            r[4*i +: 4] = 4'((v / p) % 10);
            p = p * 10;
        end
        return r;
    endfunction

    // ------------------------------------------------------------------------
    // Stimulus generator: the raw wave plus the x10 prescaler
    // ------------------------------------------------------------------------
    int period  = 40;
    bit noise   = 1'b0;
    bit bypass  = 1'b0;   // drive the raw wave even when range=1
    int raw_cnt = 0;
    bit raw     = 1'b0;
    bit raw_prev = 1'b0;
    bit div_q   = 1'b0;
    int div_cnt = 0;

    task automatic step_gen();
        if (noise) begin
            raw = 1'($urandom_range(0, 1));
        end else begin
            raw_cnt = (raw_cnt + 1) % period;
            raw     = (raw_cnt < period / 2);
        end
        if (raw && !raw_prev) begin
            div_cnt = (div_cnt + 1) % 5;
            if (div_cnt == 0) div_q = ~div_q;
        end
        raw_prev  = raw;
        signal_in = (range && !bypass) ? div_q : raw;
    endtask

    task automatic run_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            step_gen();
        end
    endtask

    // ------------------------------------------------------------------------
    // Reference model. It runs on the rising edge and works on cycle numbers
    // counted from reset release.
    // ------------------------------------------------------------------------
    typedef struct {
        int             cyc;
        logic [4*D-1:0] bcd;
        logic           rng;
        logic           ovf;
    } exp_t;

    exp_t           sb[$];
    int             arrivals[$];
    int             cyc       = 0;
    int             win_start = 1;
    int             latch_at  = 1 + G;
    int             edges     = 0;
    bit             p_prev    = 1'b0;
    bit             m_range   = 1'b0;
    logic [4*D-1:0] last_bcd  = '0;
    logic           last_rng  = 1'b0;
    logic           last_ovf  = 1'b0;
    int             chk_at    = -1;
    bit             chk_hold  = 1'b0;

    task automatic model_latch();
        bit   ovf;
        bit   pub;
        bit   change;
        bit   old_rng;
        exp_t e;
        ovf     = (edges > FULL);
        old_rng = m_range;
        pub     = 1'b1;
        change  = 1'b0;
        if (ovf && !m_range) begin
            pub     = 1'b0;
            m_range = 1'b1;
            change  = 1'b1;
        end else if (!ovf && m_range && edges < MSD_MIN) begin
            m_range = 1'b0;
            change  = 1'b1;
        end
        if (pub) begin
            e.cyc = cyc;
            e.bcd = to_bcd(ovf ? FULL : edges);
            e.rng = old_rng;
            e.ovf = ovf;
            sb.push_back(e);
            last_bcd = e.bcd;
            last_rng = e.rng;
            last_ovf = e.ovf;
        end
        chk_hold  = !pub;
        chk_at    = cyc;
        edges     = 0;
        win_start = cyc + 1 + (change ? S : 0);
        latch_at  = win_start + G;
    endtask

    initial forever begin
        @(posedge clk);
        if (!rst_n) begin
            cyc       = 0;
            win_start = 1;
            latch_at  = 1 + G;
            edges     = 0;
            p_prev    = 1'b0;
            m_range   = 1'b0;
            last_bcd  = '0;
            last_rng  = 1'b0;
            last_ovf  = 1'b0;
            chk_at    = -1;
            arrivals.delete();
            sb.delete();
        end else begin
            cyc++;
            if (signal_in && !p_prev) arrivals.push_back(cyc + LATENCY);
            p_prev = signal_in;
            while (arrivals.size() > 0 && arrivals[0] <= cyc) begin
                if (arrivals[0] == cyc && cyc >= win_start && cyc < latch_at) edges++;
                void'(arrivals.pop_front());
            end
            if (cyc == latch_at) model_latch();
        end
    end

    // ------------------------------------------------------------------------
    // Monitor: samples on the falling edge
    // ------------------------------------------------------------------------
    initial forever begin
        exp_t e;
        @(negedge clk);
        if (rst_n) begin
            if (valid) begin
                if (sb.size() == 0) begin
                    check("unexpected_valid", valid, 1'b0);
                end else begin
                    e = sb.pop_front();
                    check("valid_cycle", cyc, e.cyc);
                    check("result_bcd", result_bcd, e.bcd);
                    check("result_rng", result_rng, e.rng);
                    check("result_ovf", result_ovf, e.ovf);
                end
            end else if (sb.size() > 0 && sb[0].cyc <= cyc) begin
                check("missed_valid", valid, 1'b1);
                void'(sb.pop_front());
            end
            if (chk_at == cyc) begin
                check("range", range, m_range);
                if (chk_hold) begin
                    check("held_bcd", result_bcd, last_bcd);
                    check("held_rng", result_rng, last_rng);
                    check("held_ovf", result_ovf, last_ovf);
                end
            end
        end
    end

    task automatic set_phase(input int p, input bit nz, input bit byp);
        period = p;
        noise  = nz;
        bypass = byp;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_range"},      range,      1'b0);
        check({tag, "_result_bcd"}, result_bcd, '0);
        check({tag, "_result_rng"}, result_rng, 1'b0);
        check({tag, "_result_ovf"}, result_ovf, 1'b0);
        check({tag, "_valid"},      valid,      1'b0);
    endtask

    // ------------------------------------------------------------------------
    // Main sequence
    // ------------------------------------------------------------------------
    initial begin
        bit found;

        run_cycles(3);
        check_reset_outputs("reset");
        rst_n = 1'b1;

        // Period 40 at range 0: 25 edges per window.
        set_phase(40, 1'b0, 1'b0);
        run_cycles(3500);

        // Period 4 overflows range 0, then reads 25 on range 1.
        set_phase(4, 1'b0, 1'b0);
        run_cycles(4200);

        // Reset in the middle of a gate, with edges still arriving.
        found = 1'b0;
        for (int i = 0; i < 3000 && !found; i++) begin
            run_cycles(1);
            if (cyc >= win_start && cyc - win_start == 400 && cyc < latch_at) found = 1'b1;
        end
        check("midgate_found", found, 1'b1);
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("async_reset");
        run_cycles(4);
        rst_n = 1'b1;
        run_cycles(4200);

        // Period 200 on range 1 reads below the MSD and drops back to range 0.
        set_phase(200, 1'b0, 1'b0);
        run_cycles(3500);

        // Period 2: overflow on range 0, then 50 on range 1.
        set_phase(2, 1'b0, 1'b0);
        run_cycles(4200);

        // Bypass the divider on range 1 to force saturation (99, ovf=1).
        set_phase(2, 1'b0, 1'b1);
        run_cycles(3200);

        // Random phases.
        for (int k = 0; k < 8; k++) begin
            set_phase($urandom_range(2, 400), ($urandom_range(0, 3) == 0),
                      ($urandom_range(0, 3) == 0));
            run_cycles($urandom_range(1500, 4000));
        end

        run_cycles(10);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
